// File: rtl/mem_wb.sv
// Memory-access / write-back stage: 256x8 data memory plus the MEM/WB
// register feeding the register-file write port.
module mem_wb #(
  parameter int         MEM_DEPTH  = 256,
  parameter logic [7:0] INIT_VALUE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rst_datamem,
  input  logic        regwrite_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  store_data,
  input  logic [15:0] instruction_in,
  output logic        regwrite,
  output logic [7:0]  write_data,
  output logic [2:0]  write_addr,
  output logic [15:0] instruction_output
);

  typedef struct packed {
    logic        regwrite;
    logic [7:0]  data;
    logic [2:0]  addr;
    logic [15:0] instr;
  } mem_wb_t;

  logic [7:0] mem [MEM_DEPTH];
  logic [7:0] rdata;
  logic [7:0] wb_value;
  logic       unused_ok;
  mem_wb_t    wb_q;
  mem_wb_t    wb_d;

  // Loads are steered by mem_to_reg_in alone; mem_read_in is informational.
  assign unused_ok = mem_read_in;

  assign rdata    = mem[alu_result];
  assign wb_value = mem_to_reg_in ? rdata : alu_result;

  always_comb begin
    wb_d          = '0;
    wb_d.regwrite = regwrite_in;
    wb_d.data     = wb_value;
    wb_d.addr     = instruction_in[10:8];
    wb_d.instr    = instruction_in;
  end

  // Array clear takes priority over any store in the same cycle.
  always_ff @(posedge clk) begin
    if (rst_datamem) begin
      for (int i = 0; i < MEM_DEPTH; i++)
        mem[i] <= INIT_VALUE;
    end else if (mem_write_in && !rst) begin
      mem[alu_result] <= store_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      wb_q <= '0;
    else
      wb_q <= wb_d;
  end

  assign regwrite           = wb_q.regwrite;
  assign write_data         = wb_q.data;
  assign write_addr         = wb_q.addr;
  assign instruction_output = wb_q.instr;

endmodule

// File: tb/tb_mem_wb.sv
// Directed vector bench for mem_wb.
module tb_mem_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_datamem;
  logic        regwrite_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        mem_to_reg_in;
  logic [7:0]  alu_result;
  logic [7:0]  store_data;
  logic [15:0] instruction_in;
  logic        regwrite;
  logic [7:0]  write_data;
  logic [2:0]  write_addr;
  logic [15:0] instruction_output;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_wb dut (
    .clk(clk),
    .rst(rst),
    .rst_datamem(rst_datamem),
    .regwrite_in(regwrite_in),
    .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in),
    .mem_to_reg_in(mem_to_reg_in),
    .alu_result(alu_result),
    .store_data(store_data),
    .instruction_in(instruction_in),
    .regwrite(regwrite),
    .write_data(write_data),
    .write_addr(write_addr),
    .instruction_output(instruction_output)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        rst_dm;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic [7:0]  alu;
    logic [7:0]  sd;
    logic [15:0] ins;
    logic        e_rw;
    logic [7:0]  e_data;
    logic [2:0]  e_addr;
    logic [15:0] e_ins;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    string n, logic r, logic rd, logic w, logic mr, logic mw, logic m2r,
    logic [7:0] a, logic [7:0] s, logic [15:0] i,
    logic erw, logic [7:0] ed, logic [2:0] ea, logic [15:0] ei);
    vec_t v;
    v.name = n; v.rst = r; v.rst_dm = rd; v.rw = w; v.mr = mr;
    v.mw = mw; v.m2r = m2r; v.alu = a; v.sd = s; v.ins = i;
    v.e_rw = erw; v.e_data = ed; v.e_addr = ea; v.e_ins = ei;
    return v;
  endfunction

  task automatic drive(vec_t v);
    rst = v.rst; rst_datamem = v.rst_dm; regwrite_in = v.rw;
    mem_read_in = v.mr; mem_write_in = v.mw; mem_to_reg_in = v.m2r;
    alu_result = v.alu; store_data = v.sd; instruction_in = v.ins;
  endtask

  task automatic check(string n, logic erw, logic [7:0] ed,
                       logic [2:0] ea, logic [15:0] ei);
    n_tests++;
    if (regwrite !== erw || write_data !== ed ||
        write_addr !== ea || instruction_output !== ei) begin
      n_fail++;
      $display("FAIL %s: got rw=%b data=%h addr=%0d ins=%h, want rw=%b data=%h addr=%0d ins=%h",
               n, regwrite, write_data, write_addr, instruction_output,
               erw, ed, ea, ei);
    end
  endtask

  initial begin
    // name rst rdm rw mr mw m2r alu sd ins | rw data addr ins
    vecs.push_back(mk("rst0", 1,1,1,0,0,0, 8'h55,8'h00,16'h0500, 0,8'h00,3'd0,16'h0000));
    vecs.push_back(mk("rst1", 1,0,1,0,0,0, 8'h55,8'h00,16'h0500, 0,8'h00,3'd0,16'h0000));
    vecs.push_back(mk("rel",  0,0,1,0,0,0, 8'h55,8'h00,16'h0000, 1,8'h55,3'd0,16'h0000));
    vecs.push_back(mk("alu",  0,0,1,0,0,0, 8'h3C,8'h00,16'h0500, 1,8'h3C,3'd5,16'h0500));
    vecs.push_back(mk("stFF", 0,0,0,0,1,0, 8'hFF,8'hA7,16'h0000, 0,8'hFF,3'd0,16'h0000));
    vecs.push_back(mk("ldFF", 0,0,1,1,0,1, 8'hFF,8'h00,16'h0200, 1,8'hA7,3'd2,16'h0200));
    vecs.push_back(mk("rbw",  0,0,1,1,1,1, 8'h10,8'h99,16'h0300, 1,8'h00,3'd3,16'h0300));
    vecs.push_back(mk("ld10", 0,0,1,1,0,1, 8'h10,8'h00,16'h0400, 1,8'h99,3'd4,16'h0400));
    vecs.push_back(mk("rstst",1,0,1,0,1,0, 8'h20,8'h11,16'h0000, 0,8'h00,3'd0,16'h0000));
    vecs.push_back(mk("ld20a",0,0,1,1,0,1, 8'h20,8'h00,16'h0100, 1,8'h00,3'd1,16'h0100));
    vecs.push_back(mk("dmst", 0,1,0,0,1,0, 8'h20,8'h22,16'h0000, 0,8'h20,3'd0,16'h0000));
    vecs.push_back(mk("ld20b",0,0,1,1,0,1, 8'h20,8'h00,16'h0600, 1,8'h00,3'd6,16'h0600));
    vecs.push_back(mk("ldFFc",0,0,1,1,0,1, 8'hFF,8'h00,16'h0700, 1,8'h00,3'd7,16'h0700));
    vecs.push_back(mk("ldalu",0,0,1,1,0,0, 8'h42,8'h00,16'hF3AB, 1,8'h42,3'd3,16'hF3AB));

    foreach (vecs[k]) begin
      drive(vecs[k]);
      @(posedge clk); #1;
      check(vecs[k].name, vecs[k].e_rw, vecs[k].e_data,
            vecs[k].e_addr, vecs[k].e_ins);
    end

    // Back-to-back ALU write-backs, one per cycle, no bubbles.
    for (int rd = 0; rd < 8; rd++) begin
      drive(mk("b2b", 0,0,1,0,0,0, 8'h10 + 8'(rd), 8'h00,
               {5'b0, 3'(rd), 8'h00}, 0,0,0,0));
      @(posedge clk); #1;
      check($sformatf("b2b%0d", rd), 1'b1, 8'h10 + 8'(rd), 3'(rd),
            {5'b0, 3'(rd), 8'h00});
    end

    // Fill several words, wipe mid-stream with rst_datamem, confirm all cleared.
    for (int a = 0; a < 4; a++) begin
      drive(mk("fill", 0,0,0,0,1,0, 8'h80 + 8'(a), 8'hC0 + 8'(a),
               16'h0000, 0,0,0,0));
      @(posedge clk); #1;
    end
    drive(mk("ld80", 0,0,1,1,0,1, 8'h82,8'h00,16'h0100, 0,0,0,0));
    @(posedge clk); #1;
    check("fill82", 1'b1, 8'hC2, 3'd1, 16'h0100);
    drive(mk("wipe", 0,1,1,0,0,0, 8'h5A,8'h00,16'h0200, 0,0,0,0));
    @(posedge clk); #1;
    check("wipe", 1'b1, 8'h5A, 3'd2, 16'h0200);
    for (int a = 0; a < 4; a++) begin
      drive(mk("ldw", 0,0,1,1,0,1, 8'h80 + 8'(a), 8'h00,
               16'h0300, 0,0,0,0));
      @(posedge clk); #1;
      check($sformatf("wiped%0d", a), 1'b1, 8'h00, 3'd3, 16'h0300);
    end

    // Mid-stream rst drops the pipeline register for one edge only.
    drive(mk("mrst", 1,0,1,0,0,0, 8'h77,8'h00,16'h0400, 0,0,0,0));
    @(posedge clk); #1;
    check("midrst", 1'b0, 8'h00, 3'd0, 16'h0000);
    drive(mk("post", 0,0,1,0,0,0, 8'h78,8'h00,16'h0500, 0,0,0,0));
    @(posedge clk); #1;
    check("postrst", 1'b1, 8'h78, 3'd5, 16'h0500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
